// File: rtl/comproc_pkg.sv
// Shared comproc definitions: UART register map, status bit layout and
// serializer state encoding.
package comproc_pkg;

    localparam logic [9:0] UART_DATA_ADDR = 10'h002;
    localparam logic [9:0] UART_STAT_ADDR = 10'h004;

    localparam int unsigned STAT_BUSY_BIT    = 0;
    localparam int unsigned STAT_FULL_BIT    = 1;
    localparam int unsigned STAT_OVERRUN_BIT = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    function automatic logic [15:0] stat_word(input logic busy, input logic full,
                                              input logic ovr);
        logic [15:0] w;
        w                   = '0;
        w[STAT_BUSY_BIT]    = busy;
        w[STAT_FULL_BIT]    = full;
        w[STAT_OVERRUN_BIT] = ovr;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter. Pointers carry one extra wrap bit so
// full and empty are distinct; a push while full is taken only alongside a pop.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: FIFO-buffered data register, status
// register with sticky overrun, and a registered serial output.
module uart_tx_port
    import comproc_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  mem_addr,
    input  logic        mem_wr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        uart_tx
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    uart_state_t state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        overrun;

    logic        push;
    logic        pop;
    logic        stat_rd;
    logic        bit_done;
    logic        busy;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        unused_wr_hi;

    assign push         = mem_wr && (mem_addr == UART_DATA_ADDR);
    assign stat_rd      = !mem_wr && (mem_addr == UART_STAT_ADDR);
    assign bit_done     = (baud_cnt == BAUD_LAST);
    assign pop          = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    assign busy         = (state != IDLE) || !fifo_empty;
    assign unused_wr_hi = ^wr_data[15:8];

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_data(wr_data[7:0]),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // uart_tx follows the current state one edge later, which keeps every
    // bit exactly CLK_DIV cycles wide and gives the 2-edge start latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
        end else begin
            case (state)
                START:   uart_tx <= 1'b0;
                DATA:    uart_tx <= shift_reg[bit_idx];
                default: uart_tx <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= fifo_head;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= fifo_head;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            overrun <= 1'b0;
        end else begin
            rd_data <= stat_rd ? stat_word(busy, fifo_full, overrun) : '0;
            // A dropped byte on the same edge as a status read keeps the flag set.
            if (push && fifo_full && !pop) overrun <= 1'b1;
            else if (stat_rd)              overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: a transaction-level model predicts frames
// and register reads; independent monitors decode uart_tx and rd_data.
module tb_uart_tx_port;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FRAME      = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  mem_addr = '0;
    logic        mem_wr = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        uart_tx;
    logic        rd_req = 1'b0;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    uart_tx_port #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_addr(mem_addr),
        .mem_wr  (mem_wr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .uart_tx (uart_tx)
    );

    typedef struct {
        logic [7:0]  b;
        int unsigned fe;
    } frame_t;

    typedef struct {
        int unsigned e;
        logic [15:0] v;
    } rd_t;

    logic [7:0]  mq[$];
    frame_t      frq[$];
    rd_t         rdq[$];
    int unsigned edge_n   = 0;
    int unsigned next_pop = 0;
    logic        m_ovr    = 1'b0;

    logic        m_full, m_busy, m_ovr_pre;
    frame_t      m_f;
    rd_t         m_r;

    // Reference model: a byte leaves the queue when the line is free; each
    // frame occupies 40 cycles and its start bit appears one edge after the pop.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rst) begin
            mq.delete();
            frq.delete();
            rdq.delete();
            next_pop = 0;
            m_ovr    = 1'b0;
        end else begin
            m_full    = (mq.size() == FIFO_DEPTH);
            m_busy    = (mq.size() != 0) || (edge_n <= next_pop);
            m_ovr_pre = m_ovr;
            if (mq.size() != 0 && edge_n >= next_pop) begin
                m_f.b = mq.pop_front();
                m_f.fe = edge_n + 1;
                frq.push_back(m_f);
                next_pop = edge_n + FRAME;
            end
            if (mem_wr && mem_addr == 10'h002) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(wr_data[7:0]);
                else m_ovr = 1'b1;
            end else if (!mem_wr && mem_addr == 10'h004) begin
                m_ovr = 1'b0;
            end
            if (rd_req) begin
                m_r.e = edge_n;
                m_r.v = (!mem_wr && mem_addr == 10'h004)
                        ? {13'b0, m_ovr_pre, m_full, m_busy} : 16'h0000;
                rdq.push_back(m_r);
            end
        end
    end

    rd_t mon_r;
    always @(negedge clk) begin
        while (rdq.size() != 0 && rdq[0].e <= edge_n) begin
            mon_r = rdq.pop_front();
            tests = tests + 1;
            if (mon_r.e != edge_n || rd_data !== mon_r.v) begin
                fails = fails + 1;
                $display("FAIL rd_data@edge%0d: got %h, required %h", mon_r.e, rd_data, mon_r.v);
            end
        end
    end

    // Frame monitor: any low on an idle line starts a 40-sample capture.
    initial begin
        frame_t      f;
        logic        have, aborted;
        logic [39:0] got, want;
        int unsigned start_e;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                start_e = edge_n;
                have    = (frq.size() != 0);
                if (have) f = frq.pop_front();
                aborted = 1'b0;
                got     = '0;
                for (int k = 0; k < 40; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[k] = uart_tx;
                end
                if (!aborted) begin
                    tests = tests + 1;
                    if (!have) begin
                        fails = fails + 1;
                        $display("FAIL frame: got unexpected frame %h at edge %0d, required none",
                                 got, start_e);
                    end else begin
                        for (int k = 0; k < 40; k++) begin
                            if (k < 4)       want[k] = 1'b0;
                            else if (k >= 36) want[k] = 1'b1;
                            else             want[k] = f.b[(k/4)-1];
                        end
                        if (got !== want || start_e != f.fe) begin
                            fails = fails + 1;
                            $display("FAIL frame: got %h at edge %0d, required %h (byte %h) at edge %0d",
                                     got, start_e, want, f.b, f.fe);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic wr, input logic [9:0] a, input logic [15:0] d, input logic rq);
        mem_wr   = wr;
        mem_addr = a;
        wr_data  = d;
        rd_req   = rq;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) cyc(1'b0, 10'h3F0, 16'h0000, 1'b0);
    endtask

    task automatic drain();
        int unsigned t = 0;
        while (!(mq.size() == 0 && edge_n >= next_pop + 3)) begin
            idle(1);
            t++;
            if (t > 2000) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL drain: got queue %0d after %0d cycles, required empty", mq.size(), t);
                return;
            end
        end
        idle(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a;
        int unsigned r, t;

        #1 rst = 1'b1;
        #1;
        check("reset_tx", {15'b0, uart_tx}, 16'h0001);
        check("reset_rd", rd_data, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Idle reads
        cyc(1'b0, 10'h004, 16'h0, 1'b1);
        cyc(1'b0, 10'h006, 16'h0, 1'b1);
        cyc(1'b0, 10'h002, 16'h0, 1'b1);
        idle(1);

        // Single frame
        cyc(1'b1, 10'h002, 16'h0055, 1'b0);
        drain();

        // Five back-to-back bytes, then status shows no overrun
        for (int i = 0; i < 5; i++) cyc(1'b1, 10'h002, 16'h0041 + 16'(i), 1'b0);
        drain();
        cyc(1'b0, 10'h004, 16'h0, 1'b1);
        idle(1);

        // Overrun: sixth write before next pop, then two status reads
        for (int i = 0; i < 6; i++) cyc(1'b1, 10'h002, 16'h0061 + 16'(i), 1'b0);
        cyc(1'b0, 10'h004, 16'h0, 1'b1);
        cyc(1'b0, 10'h004, 16'h0, 1'b1);

        // Write on the STOP->START pop edge while full
        t = 0;
        while (edge_n + 1 != next_pop && t < 200) begin
            idle(1);
            t++;
        end
        check("pop_edge_full", 16'(mq.size()), 16'(FIFO_DEPTH));
        cyc(1'b1, 10'h002, 16'h005A, 1'b0);
        cyc(1'b0, 10'h004, 16'h0, 1'b1);
        drain();

        // Reset during data bit 3 of 0xF0
        cyc(1'b1, 10'h002, 16'h00F0, 1'b0);
        idle(19);
        #1 rst = 1'b1;
        #1;
        check("async_rst_tx", {15'b0, uart_tx}, 16'h0001);
        check("async_rst_rd", rd_data, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);
        cyc(1'b0, 10'h004, 16'h0, 1'b1);
        idle(100);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            a = 10'($urandom);
            if (a == 10'h002 || a == 10'h004) a = 10'h100;
            if (r < 12)      cyc(1'b1, 10'h002, 16'($urandom), 1'b0);
            else if (r < 20) cyc(1'b0, 10'h004, 16'($urandom), 1'b1);
            else if (r < 22) cyc(1'b0, 10'h002, 16'($urandom), 1'b1);
            else if (r < 25) cyc(1'b0, a, 16'($urandom), 1'b1);
            else if (r < 27) cyc(1'b1, 10'h004, 16'($urandom), 1'b1);
            else if (r < 29) cyc(1'b1, a, 16'($urandom), 1'b1);
            else             idle(1);
        end
        drain();
        idle(2);

        check("frames_left", 16'(frq.size()), 16'h0000);
        check("reads_left", 16'(rdq.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port mem_addr, input, 10: CPU byte address.
REQ-006 SHALL have port mem_wr, input, 1: CPU write strobe for the current cycle.
REQ-007 SHALL have port wr_data, input, 16: CPU write data; only bits [7:0] are used.
REQ-008 SHALL have port rd_data, output, 16: registered read data.
REQ-009 SHALL have port uart_tx, output, 1: serial line, 8N1 format, idle high.

Function
REQ-010 SHALL treat mem_wr=1 with mem_addr=0x002 as a push of wr_data[7:0] into the FIFO.
REQ-011 SHALL, on a push while the FIFO is full and no pop occurs on the same edge, drop the byte and set the sticky overrun flag.
REQ-012 SHALL accept a push while full when a pop occurs on the same edge; no overrun in that case.
REQ-013 SHALL update rd_data on every edge:
- mem_wr=0 and mem_addr=0x004: {13'b0, overrun, full, busy}.
- otherwise: 16'h0000.
REQ-014 SHALL clear overrun on the edge that samples a status read (REQ-013); a same-edge overrun event wins and leaves the flag set.
REQ-015 SHALL define busy=1 whenever the serializer is not IDLE or the FIFO is non-empty.
REQ-016 SHALL ignore all other addresses, and reads of 0x002, with no side effects.
REQ-017 SHALL implement serializer states IDLE, START, DATA, STOP.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop the head into the shift register and enter START on the same edge.
REQ-019 SHALL drive uart_tx=0 for CLK_DIV cycles in START, then go to DATA.
REQ-020 SHALL send 8 data bits LSB first in DATA, CLK_DIV cycles each, using a 3-bit bit index.
REQ-021 SHALL drive uart_tx=1 for CLK_DIV cycles in STOP.
REQ-022 SHALL, at the end of STOP, go to IDLE, or directly to START with a fresh pop if the FIFO is non-empty (back-to-back frames, no idle gap).
REQ-023 SHALL hold latency at exactly 2 edges from the push-sampling edge to uart_tx falling, when the FIFO was empty and the serializer was IDLE.
REQ-024 SHALL register uart_tx with no combinational path from its inputs.
REQ-025 SHALL keep bit timing exact: every frame lasts 10*CLK_DIV cycles.
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH and keep an extra count bit so full and empty are distinct.

Reset
REQ-027 SHALL, while rst=1, immediately force uart_tx=1, rd_data=0, state=IDLE, FIFO empty, overrun=0, and the baud counter and bit index to 0.
REQ-028 SHALL abandon any frame in progress on reset, including a partial frame, and not resume it after reset is released.

Structure
REQ-029 SHALL take the address constants UART_DATA_ADDR=0x002 and UART_STAT_ADDR=0x004, the status bit positions, and the serializer state enum from the shared comproc package.
REQ-030 SHALL place the FIFO in one sub-module, uart_tx_fifo, with push/pop/full/empty/data ports.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-031 SHALL check: write 0x0055 to 0x002 -> uart_tx falls 2 edges later, then bits 0,1,0,1,0,1,0,1,0,1 at 4 cycles each, then high; frame is 40 cycles.
REQ-032 SHALL check: 5 back-to-back writes 0x41..0x45 with no reads -> 5 contiguous frames, 200 cycles, no overrun.
REQ-033 SHALL check: FIFO full with the serializer busy, and a 6th write arriving before the next pop -> byte dropped; status read returns 0x0007; a second status read returns 0x0003.
REQ-034 SHALL check: status read while idle -> rd_data=0x0000 one edge later; read of 0x006 -> 0x0000.
REQ-035 SHALL check: rst asserted during data bit 3 -> uart_tx=1 with no clock edge; after release, status reads 0x0000 and no further frame is sent.
REQ-036 SHALL check: write landing on the same edge as the STOP->START pop while the FIFO is full -> write accepted, overrun stays 0.
